// File: rtl/funct_generator_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : funct_generator_fifo_reader
// Purpose  : Paces FIFO pops with a programmable tick and presents each word
//            downstream over a valid/ready handshake, flagging underruns.
// Revision : 1.0 - initial release
// ============================================================================
module funct_generator_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  input  logic                  clr_underrun,
  output logic                  underrun,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic                  r_stop_pend;
  logic                  r_underrun;
  logic [DATA_WIDTH-1:0] r_sample;
  logic                  w_tick;
  logic                  w_set_underrun;
  logic                  w_in_xfer;

  assign w_tick         = (r_state != S_IDLE) && (r_cnt == '0);
  assign w_set_underrun = (r_state == S_WAIT) && w_tick && fifo_empty;
  assign w_in_xfer      = (r_state == S_READ) || (r_state == S_CAPTURE) ||
                          (r_state == S_PRESENT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start && !stop) w_state_nxt = S_WAIT;
      // A stop in WAIT outranks a coincident tick so nothing new is popped.
      S_WAIT: begin
        if (stop)                         w_state_nxt = S_IDLE;
        else if (w_tick && !fifo_empty)   w_state_nxt = S_READ;
      end
      S_READ:    w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_PRESENT;
      S_PRESENT: begin
        if (sample_ready) w_state_nxt = (r_stop_pend || stop) ? S_IDLE : S_WAIT;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Counter free-runs in every active state; ticks outside WAIT are simply ignored.
      if (w_state_nxt == S_IDLE)  r_cnt <= '0;
      else if (r_state == S_IDLE) r_cnt <= div;
      else if (r_cnt == '0)       r_cnt <= div;
      else                        r_cnt <= r_cnt - 1'b1;

      if (w_state_nxt == S_IDLE)  r_stop_pend <= 1'b0;
      else if (stop && w_in_xfer) r_stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample   <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (r_state == S_CAPTURE) r_sample <= fifo_data;
      if (w_set_underrun)       r_underrun <= 1'b1;
      else if (clr_underrun)    r_underrun <= 1'b0;
    end
  end

  assign fifo_rd      = (r_state == S_READ);
  assign sample_valid = (r_state == S_PRESENT);
  assign busy         = (r_state != S_IDLE);
  assign sample_o     = r_sample;
  assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_funct_generator_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_funct_generator_fifo_reader
// Purpose  : Directed scenarios plus randomized playback against a
//            transaction-level model of the paced FIFO reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_funct_generator_fifo_reader;

  logic        clk = 1'b0;
  logic        rst, start, stop, fifo_empty, fifo_rd, sample_valid;
  logic        sample_ready, clr_underrun, underrun, busy;
  logic [15:0] div;
  logic [7:0]  fifo_data, sample_o;
  logic [7:0]  fq[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  funct_generator_fifo_reader #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .sample_o(sample_o), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .clr_underrun(clr_underrun), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; outputs are observed at the falling edge, where the upstream FIFO also pops.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (fifo_rd && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; div = 0; fifo_empty = 1; fifo_data = 0;
    sample_ready = 0; clr_underrun = 0;
    repeat (2) @(negedge clk);
    total_cnt++; if (sample_o !== 8'h00) $display("FAIL reset_sample: got %h expected 00", sample_o); else pass_cnt++;
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", sample_valid); else pass_cnt++;
    total_cnt++; if (fifo_rd !== 1'b0) $display("FAIL reset_rd: got %b expected 0", fifo_rd); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", underrun); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic_playback();
    logic [13:0] rd_mask, v_mask;
    logic [7:0]  s0, s1;
    int          vc;
    rd_mask = '0; v_mask = '0; s0 = 0; s1 = 0; vc = 0;
    fq.delete(); fq.push_back(8'hA5); fq.push_back(8'h3C); fifo_empty = 0;
    div = 16'd3; sample_ready = 1;
    pulse_start();
    for (int c = 0; c < 14; c++) begin
      if (c > 0) step();
      rd_mask[c] = fifo_rd;
      v_mask[c]  = sample_valid;
      if (sample_valid) begin
        if (vc == 0) s0 = sample_o; else s1 = sample_o;
        vc++;
      end
    end
    total_cnt++; if (rd_mask !== 14'h0110) $display("FAIL basic_rd_pattern: got %h expected 0110", rd_mask); else pass_cnt++;
    total_cnt++; if (v_mask !== 14'h0440) $display("FAIL basic_valid_pattern: got %h expected 0440", v_mask); else pass_cnt++;
    total_cnt++; if (s0 !== 8'hA5) $display("FAIL basic_first_sample: got %h expected a5", s0); else pass_cnt++;
    total_cnt++; if (s1 !== 8'h3C) $display("FAIL basic_second_sample: got %h expected 3c", s1); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b1) $display("FAIL basic_drain_underrun: got %b expected 1", underrun); else pass_cnt++;
    stop = 1; step(); stop = 0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_stop_busy: got %b expected 0", busy); else pass_cnt++;
    clr_underrun = 1; step(); clr_underrun = 0;
  endtask

  task automatic test_underrun();
    logic bad;
    bad = 0;
    fq.delete(); fifo_empty = 1; div = 16'd0; sample_ready = 1;
    pulse_start();
    total_cnt++; if (underrun !== 1'b0) $display("FAIL under_before_tick: got %b expected 0", underrun); else pass_cnt++;
    for (int c = 1; c < 6; c++) begin
      step();
      if (fifo_rd !== 1'b0 || sample_o !== 8'h3C || underrun !== 1'b1) bad = 1;
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL under_hold: got rd=%b sample=%h underrun=%b expected 0 3c 1", fifo_rd, sample_o, underrun); else pass_cnt++;
    clr_underrun = 1; step(); clr_underrun = 0;
    total_cnt++; if (underrun !== 1'b1) $display("FAIL under_set_wins: got %b expected 1", underrun); else pass_cnt++;
    stop = 1; step(); stop = 0;
    clr_underrun = 1; step(); clr_underrun = 0;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL under_clear: got %b expected 0", underrun); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int   rd_cnt, v_cnt;
    logic stable;
    rd_cnt = 0; v_cnt = 0; stable = 1;
    fq.delete(); fq.push_back(8'h5A); fq.push_back(8'h77); fq.push_back(8'h99); fifo_empty = 0;
    div = 16'd1; sample_ready = 0;
    pulse_start();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) step();
      if (fifo_rd) rd_cnt++;
      if (sample_valid) begin
        v_cnt++;
        if (sample_o !== 8'h5A) stable = 0;
      end
    end
    total_cnt++; if (rd_cnt !== 1) $display("FAIL bp_single_pop: got %0d expected 1", rd_cnt); else pass_cnt++;
    total_cnt++; if (v_cnt !== 11) $display("FAIL bp_valid_cycles: got %0d expected 11", v_cnt); else pass_cnt++;
    total_cnt++; if (stable !== 1'b1) $display("FAIL bp_sample_stable: got %b expected 1", stable); else pass_cnt++;
    sample_ready = 1; step(); sample_ready = 0;
    total_cnt++; if (sample_valid !== 1'b0) $display("FAIL bp_after_accept: got %b expected 0", sample_valid); else pass_cnt++;
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_stop_pending();
    logic bad;
    bad = 0;
    fq.delete(); fq.push_back(8'hC3); fq.push_back(8'h11); fifo_empty = 0;
    div = 16'd0; sample_ready = 0;
    pulse_start();
    repeat (3) step();
    total_cnt++; if (sample_valid !== 1'b1) $display("FAIL sp_present: got %b expected 1", sample_valid); else pass_cnt++;
    stop = 1; step(); stop = 0;
    repeat (2) begin
      if (sample_valid !== 1'b1 || busy !== 1'b1) bad = 1;
      step();
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL sp_hold: got valid=%b busy=%b expected 1 1", sample_valid, busy); else pass_cnt++;
    sample_ready = 1; step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL sp_idle_busy: got %b expected 0", busy); else pass_cnt++;
    bad = 0;
    repeat (6) begin
      step();
      if (fifo_rd !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL sp_no_more_reads: got rd=%b busy=%b expected 0 0", fifo_rd, busy); else pass_cnt++;
    total_cnt++; if (sample_o !== 8'hC3) $display("FAIL sp_sample_kept: got %h expected c3", sample_o); else pass_cnt++;
    sample_ready = 0;
  endtask

  task automatic test_start_stop_together();
    logic bad;
    bad = 0;
    start = 1; stop = 1; step(); start = 0; stop = 0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ss_stays_idle: got %b expected 0", busy); else pass_cnt++;
    repeat (3) begin
      step();
      if (busy !== 1'b0 || fifo_rd !== 1'b0) bad = 1;
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL ss_quiet: got busy=%b rd=%b expected 0 0", busy, fifo_rd); else pass_cnt++;
  endtask

  task automatic test_rst_in_read();
    logic bad;
    bad = 0;
    fq.delete(); fq.push_back(8'hE7); fifo_empty = 0; div = 16'd0; sample_ready = 1;
    pulse_start();
    step();
    total_cnt++; if (fifo_rd !== 1'b1) $display("FAIL rr_in_read: got %b expected 1", fifo_rd); else pass_cnt++;
    rst = 1; #1;
    total_cnt++; if ({fifo_rd, sample_valid, busy, underrun} !== 4'b0000 || sample_o !== 8'h00)
      $display("FAIL rr_async: got rd=%b v=%b busy=%b ur=%b s=%h expected 0 0 0 0 00", fifo_rd, sample_valid, busy, underrun, sample_o); else pass_cnt++;
    step(); rst = 0;
    repeat (5) begin
      step();
      if (sample_valid !== 1'b0 || busy !== 1'b0 || sample_o !== 8'h00) bad = 1;
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL rr_discard: got v=%b busy=%b s=%h expected 0 0 00", sample_valid, busy, sample_o); else pass_cnt++;
  endtask

  // Model: ticks fall on a fixed arithmetic grid from start; a tick while idle-waiting pops one word.
  task automatic test_random();
    logic [7:0] mq[$];
    logic [7:0] m_word, w;
    logic       m_busy, m_under, exp_rd, exp_valid;
    int         pop_c, n, d;
    for (int it = 0; it < 20; it++) begin
      rst = 1; step(); rst = 0;
      fq.delete(); mq.delete();
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        w = 8'($urandom_range(1, 255)); fq.push_back(w); mq.push_back(w);
      end
      fifo_empty = (fq.size() == 0);
      d = $urandom_range(0, 4); div = 16'(d);
      m_busy = 0; m_under = 0; pop_c = -10; m_word = 0;
      pulse_start();
      for (int c = 0; c < 50; c++) begin
        if (c > 0) step();
        exp_rd    = m_busy && (c == pop_c);
        exp_valid = m_busy && (c >= pop_c + 2);
        total_cnt++; if (fifo_rd !== exp_rd) $display("FAIL rnd_rd it%0d c%0d: got %b expected %b", it, c, fifo_rd, exp_rd); else pass_cnt++;
        total_cnt++; if (sample_valid !== exp_valid) $display("FAIL rnd_valid it%0d c%0d: got %b expected %b", it, c, sample_valid, exp_valid); else pass_cnt++;
        total_cnt++; if (underrun !== m_under) $display("FAIL rnd_underrun it%0d c%0d: got %b expected %b", it, c, underrun, m_under); else pass_cnt++;
        if (exp_valid) begin
          total_cnt++; if (sample_o !== m_word) $display("FAIL rnd_sample it%0d c%0d: got %h expected %h", it, c, sample_o, m_word); else pass_cnt++;
        end
        sample_ready = ($urandom_range(0, 2) != 0);
        if (m_busy) begin
          if (exp_valid && sample_ready) m_busy = 0;
        end else if ((c % (d + 1)) == d) begin
          if (mq.size() > 0) begin
            m_busy = 1; pop_c = c + 1; m_word = mq.pop_front();
          end else begin
            m_under = 1;
          end
        end
      end
      sample_ready = 0;
    end
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_basic_playback();
    test_underrun();
    test_backpressure();
    test_stop_pending();
    test_start_stop_together();
    test_rst_in_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/funct_generator_fifo_reader.md
FUNCT_GENERATOR_FIFO_READER -- requirements
Module: funct_generator_fifo_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the sample width.
REQ-002 The block SHALL have parameter DIV_WIDTH, default 16, giving the pacing divider width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: begin playback (pulse).
REQ-006 The block SHALL have port stop, input, 1 bit: end playback (pulse).
REQ-007 The block SHALL have port div, input, DIV_WIDTH bits: tick period minus one, in clk cycles.
REQ-008 The block SHALL have port fifo_empty, input, 1 bit: the upstream FIFO holds no word.
REQ-009 The block SHALL have port fifo_rd, output, 1 bit: FIFO pop strobe; read data is valid one cycle later.
REQ-010 The block SHALL have port fifo_data, input, DATA_WIDTH bits: FIFO read data.
REQ-011 The block SHALL have port sample_o, output, DATA_WIDTH bits: current output sample (registered).
REQ-012 The block SHALL have port sample_valid, output, 1 bit: sample_o is offered downstream.
REQ-013 The block SHALL have port sample_ready, input, 1 bit: downstream accepts sample_o.
REQ-014 The block SHALL have port clr_underrun, input, 1 bit: clear the sticky underrun flag.
REQ-015 The block SHALL have port underrun, output, 1 bit: sticky flag, tick while FIFO empty.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, READ, CAPTURE and PRESENT, all registered.
REQ-018 Tick counter: loaded with div on leaving IDLE; decrements each cycle outside IDLE; at 0 raises tick for one cycle and reloads div; div=0 gives a tick every cycle.
REQ-019 In IDLE, start=1 and stop=0 SHALL move the FSM to WAIT; start and stop high together SHALL keep it in IDLE (stop wins).
REQ-020 In WAIT, tick with fifo_empty=0 SHALL move the FSM to READ; tick with fifo_empty=1 SHALL set underrun, hold sample_o, and stay in WAIT.
REQ-021 fifo_rd SHALL be 1 exactly in READ, so it lasts one cycle per pop, and SHALL never assert in other states.
REQ-022 READ SHALL always go to CAPTURE; CAPTURE SHALL load sample_o from fifo_data and go to PRESENT.
REQ-023 sample_valid SHALL be 1 exactly in PRESENT; sample_o SHALL stay stable while sample_valid=1.
REQ-024 In PRESENT, sample_ready=1 SHALL complete the transfer and return the FSM to WAIT (or IDLE if a stop is pending).
REQ-025 Latency: tick in WAIT at cycle T SHALL give fifo_rd at T+1 and sample_valid at T+3.
REQ-026 Ticks that occur in READ, CAPTURE or PRESENT SHALL be dropped without being counted or queued; the counter SHALL keep running.
REQ-027 stop in WAIT SHALL go to IDLE next cycle; stop in READ, CAPTURE or PRESENT SHALL set stop_pend, which is applied after the PRESENT handshake, so no popped word is lost.
REQ-028 underrun and clr_underrun high in the same cycle SHALL leave underrun = 1 (set wins); underrun SHALL be unaffected by start and stop.
REQ-029 Going to IDLE SHALL clear stop_pend and the tick counter; sample_o SHALL keep its last value.
REQ-030 A change to div SHALL take effect at the next reload of the counter.

Reset
REQ-031 While rst=1, the block SHALL set state=IDLE, sample_o=0, sample_valid=0, fifo_rd=0, underrun=0, busy=0, stop_pend=0 and counter=0.
REQ-032 rst asserted mid-operation (including in READ) SHALL abort at once; the popped word is discarded.

Verification
REQ-033 The bench SHALL cover: div=3, FIFO holds A5,3C, sample_ready=1, start -> fifo_rd every 4 cycles; sample_o=A5 then 3C, sample_valid for 1 cycle each.
REQ-034 The bench SHALL cover: div=0, fifo_empty=1 after start -> underrun=1 on the first tick, fifo_rd stays 0, sample_o held; clr_underrun -> underrun=0.
REQ-035 The bench SHALL cover: sample_ready=0 for 10 cycles, div=1 -> one word popped only, sample_o stable, dropped ticks give no extra fifo_rd.
REQ-036 The bench SHALL cover: stop during PRESENT -> FSM stays until sample_ready=1, then IDLE, busy=0, no further fifo_rd.
REQ-037 The bench SHALL cover: start and stop together in IDLE -> stays IDLE; clr_underrun and underrun set together -> underrun=1.
REQ-038 The bench SHALL cover: rst pulse in READ -> all outputs at reset values next cycle, no sample_valid.
